lattuino_spm_ctrl: RTL and testbench

//  SPM page-programming engine upstream of the writable program memory.

---
 rtl/lattuino_spm_ctrl_if.sv | 28 ++
 rtl/lattuino_spm_ctrl.sv | 140 ++++++++++++++
 tb/tb_lattuino_spm_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/lattuino_spm_ctrl_if.sv
// CPU-side SPM command port and PM write port of the page-programming engine.
// The engine itself uses the slave modport.
interface lattuino_spm_ctrl_if #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_W    = 13
);
    logic                 spm_i;
    logic [1:0]           cmd_i;
    logic [ADDR_W-1:0]    addr_i;
    logic [WORD_SIZE-1:0] data_i;
    logic                 busy_o;
    logic                 done_o;
    logic                 err_o;
    logic                 pm_sel_o;
    logic                 pm_we_o;
    logic [ADDR_W-1:0]    pm_addr_o;
    logic [WORD_SIZE-1:0] pm_data_o;

    modport slave (
        input  spm_i, cmd_i, addr_i, data_i,
        output busy_o, done_o, err_o, pm_sel_o, pm_we_o, pm_addr_o, pm_data_o
    );

    modport master (
        output spm_i, cmd_i, addr_i, data_i,
        input  busy_o, done_o, err_o, pm_sel_o, pm_we_o, pm_addr_o, pm_data_o
    );
endinterface

// File: rtl/lattuino_spm_ctrl.sv
// SPM page-programming engine: buffers CPU fill words, then erases or writes
// one program-memory page, one word per clock, while stalling the CPU.
module lattuino_spm_ctrl #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_W    = 13,
    parameter int PAGE_W    = 6
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    lattuino_spm_ctrl_if.slave  bus
);
    localparam int PAGE_WORDS = 2 ** PAGE_W;

    localparam logic [1:0] CMD_FILL  = 2'b00;
    localparam logic [1:0] CMD_ERASE = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ERASE = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                     state_r;
    state_t                     next_state_s;
    logic [PAGE_W-1:0]          cnt_r;
    logic [ADDR_W-PAGE_W-1:0]   page_r;
    logic                       err_r;
    logic [WORD_SIZE-1:0]       page_buf_r [PAGE_WORDS];
    logic                       last_s;

    assign last_s = (cnt_r == {PAGE_W{1'b1}});

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode: only erase/write strobes leave IDLE
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.spm_i && (bus.cmd_i == CMD_ERASE)) begin
                    next_state_s = ST_ERASE;
                end else if (bus.spm_i && (bus.cmd_i == CMD_WRITE)) begin
                    next_state_s = ST_WRITE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ERASE, ST_WRITE: begin
                if (last_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Page buffer, word counter, page latch and sticky error flag
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_r  <= {PAGE_W{1'b0}};
            page_r <= {(ADDR_W-PAGE_W){1'b0}};
            err_r  <= 1'b0;
            for (int i = 0; i < PAGE_WORDS; i++) begin
                page_buf_r[i] <= {WORD_SIZE{1'b1}};
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.spm_i) begin
                        case (bus.cmd_i)
                            CMD_FILL: page_buf_r[bus.addr_i[PAGE_W-1:0]] <= bus.data_i;
                            CMD_ERASE, CMD_WRITE: begin
                                page_r <= bus.addr_i[ADDR_W-1:PAGE_W];
                                cnt_r  <= {PAGE_W{1'b0}};
                                err_r  <= 1'b0;
                            end
                            default: err_r <= 1'b1;
                        endcase
                    end
                end
                ST_ERASE: cnt_r <= cnt_r + PAGE_W'(1);
                ST_WRITE: begin
                    // Consumed words return to all-ones so the next page starts clean
                    cnt_r               <= cnt_r + PAGE_W'(1);
                    page_buf_r[cnt_r]   <= {WORD_SIZE{1'b1}};
                end
                default: ;
            endcase
            if (bus.spm_i && (state_r != ST_IDLE)) begin
                err_r <= 1'b1;
            end
        end
    end

    // Output decode from registered state; PM port is only driven while it is owned
    always_comb begin
        bus.busy_o    = 1'b0;
        bus.done_o    = 1'b0;
        bus.pm_sel_o  = 1'b0;
        bus.pm_we_o   = 1'b0;
        bus.pm_addr_o = {ADDR_W{1'b0}};
        bus.pm_data_o = {WORD_SIZE{1'b0}};
        case (state_r)
            ST_ERASE: begin
                bus.busy_o    = 1'b1;
                bus.pm_sel_o  = 1'b1;
                bus.pm_we_o   = 1'b1;
                bus.pm_addr_o = {page_r, cnt_r};
                bus.pm_data_o = {WORD_SIZE{1'b1}};
            end
            ST_WRITE: begin
                bus.busy_o    = 1'b1;
                bus.pm_sel_o  = 1'b1;
                bus.pm_we_o   = 1'b1;
                bus.pm_addr_o = {page_r, cnt_r};
                bus.pm_data_o = page_buf_r[cnt_r];
            end
            ST_DONE: begin
                bus.busy_o = 1'b1;
                bus.done_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.err_o = err_r;

endmodule

// File: tb/tb_lattuino_spm_ctrl.sv
// Directed bench for lattuino_spm_ctrl with a behavioural program-memory model.
module tb_lattuino_spm_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    lattuino_spm_ctrl_if bus_if ();

    lattuino_spm_ctrl dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    bit [15:0] pm_mem [0:8191];
    bit        pm_vld [0:8191];

    // Program memory: writes land on the rising edge while the engine drives it
    always @(posedge clk) begin
        if (bus_if.pm_we_o && bus_if.pm_sel_o) begin
            pm_mem[bus_if.pm_addr_o] <= bus_if.pm_data_o;
            pm_vld[bus_if.pm_addr_o] <= 1'b1;
        end
    end

    int n_chk = 0;
    int n_err = 0;
    int nbusy, nwe, ndone, done_at, we_first, bad;
    logic timed_out;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic spm_pulse(input logic [1:0] cmd, input logic [12:0] addr, input logic [15:0] data);
        bus_if.spm_i  = 1'b1;
        bus_if.cmd_i  = cmd;
        bus_if.addr_i = addr;
        bus_if.data_i = data;
        @(negedge clk);
        bus_if.spm_i  = 1'b0;
    endtask

    // Issue an erase/write and follow it to idle; optional stray strobe / reset injection
    task automatic run_op(input logic [1:0] cmd, input logic [12:0] addr, input int inj_k, input int rst_k);
        spm_pulse(cmd, addr, 16'h0000);
        nbusy = 0; nwe = 0; ndone = 0; done_at = -1; we_first = -1; bad = 0;
        timed_out = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (k == rst_k + 1) rst_n = 1'b1;
            if (!bus_if.busy_o) begin
                timed_out = 1'b0;
                break;
            end
            nbusy++;
            if (bus_if.pm_we_o) begin
                if (!bus_if.pm_sel_o) bad++;
                if (bus_if.pm_addr_o[12:6] != addr[12:6] || bus_if.pm_addr_o[5:0] != nwe[5:0]) bad++;
                if (nwe == 0) we_first = k;
                nwe++;
            end
            if (bus_if.done_o) begin
                ndone++;
                done_at = k;
            end
            if (k == inj_k) begin
                bus_if.spm_i  = 1'b1;
                bus_if.cmd_i  = 2'b00;
                bus_if.addr_i = 13'h0003;
                bus_if.data_i = 16'hDEAD;
            end else begin
                bus_if.spm_i  = 1'b0;
            end
            if (k == rst_k) rst_n = 1'b0;
            @(negedge clk);
        end
        bus_if.spm_i = 1'b0;
        check_val("op_timeout", {31'd0, timed_out}, 32'd0);
    endtask

    task automatic check_full_op(input string tag);
        check_val({tag, "_busy_cycles"}, nbusy, 32'd65);
        check_val({tag, "_we_cycles"}, nwe, 32'd64);
        check_val({tag, "_done_pulses"}, ndone, 32'd1);
        check_val({tag, "_done_at"}, done_at, 32'd64);
        check_val({tag, "_first_we"}, we_first, 32'd0);
        check_val({tag, "_bad_addr_sel"}, bad, 32'd0);
    endtask

    task automatic fill_ramp(input logic [15:0] base);
        for (int i = 0; i < 64; i++) begin
            spm_pulse(2'b00, 13'(13'h1A80 | i), 16'(base + i));
        end
    endtask

    initial begin
        logic [12:0] a;
        bus_if.spm_i  = 1'b0;
        bus_if.cmd_i  = 2'b00;
        bus_if.addr_i = 13'h0000;
        bus_if.data_i = 16'h0000;
        repeat (2) @(negedge clk);
        check_val("rst_busy", {31'd0, bus_if.busy_o}, 32'd0);
        check_val("rst_done", {31'd0, bus_if.done_o}, 32'd0);
        check_val("rst_err", {31'd0, bus_if.err_o}, 32'd0);
        check_val("rst_sel", {31'd0, bus_if.pm_sel_o}, 32'd0);
        check_val("rst_we", {31'd0, bus_if.pm_we_o}, 32'd0);
        check_val("rst_addr", {19'd0, bus_if.pm_addr_o}, 32'd0);
        check_val("rst_data", {16'd0, bus_if.pm_data_o}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reserved command in IDLE only sets the error flag
        spm_pulse(2'b11, 13'h0040, 16'h1111);
        check_val("resv_err", {31'd0, bus_if.err_o}, 32'd1);
        check_val("resv_busy", {31'd0, bus_if.busy_o}, 32'd0);

        // Erase of the top page; accepting it clears err
        run_op(2'b01, 13'h1FC5, -1, -1);
        check_full_op("erase");
        check_val("erase_err", {31'd0, bus_if.err_o}, 32'd0);
        for (int i = 0; i < 64; i++) begin
            a = 13'(13'h1FC0 + i);
            check_val("erase_data", {16'd0, pm_mem[a]}, 32'h0000FFFF);
        end
        check_val("erase_below_untouched", {31'd0, pm_vld[13'h1FBF]}, 32'd0);

        // Full page write of a ramp, fill addresses carry junk upper bits
        fill_ramp(16'hA000);
        check_val("fill_busy", {31'd0, bus_if.busy_o}, 32'd0);
        run_op(2'b10, 13'h0040, -1, -1);
        check_full_op("write");
        check_val("write_err", {31'd0, bus_if.err_o}, 32'd0);
        for (int i = 0; i < 64; i++) begin
            a = 13'(13'h0040 + i);
            check_val("write_data", {16'd0, pm_mem[a]}, 32'(16'hA000 + i));
        end
        check_val("write_below_untouched", {31'd0, pm_vld[13'h003F]}, 32'd0);
        check_val("write_above_untouched", {31'd0, pm_vld[13'h0080]}, 32'd0);

        // Second write without fills: buffer has cleared itself
        run_op(2'b10, 13'h0040, -1, -1);
        check_full_op("rewrite");
        for (int i = 0; i < 64; i++) begin
            a = 13'(13'h0040 + i);
            check_val("rewrite_data", {16'd0, pm_mem[a]}, 32'h0000FFFF);
        end

        // Stray fill strobe at cycle 10 of a write is dropped and flagged
        fill_ramp(16'hA000);
        run_op(2'b10, 13'h00C0, 10, -1);
        check_full_op("stray");
        check_val("stray_err", {31'd0, bus_if.err_o}, 32'd1);
        for (int i = 0; i < 64; i++) begin
            a = 13'(13'h00C0 + i);
            check_val("stray_data", {16'd0, pm_mem[a]}, 32'(16'hA000 + i));
        end
        run_op(2'b01, 13'h0200, -1, -1);
        check_val("erase_clears_err", {31'd0, bus_if.err_o}, 32'd0);

        // Reset during cycle 19 of a write: words 0..18 new, rest keep old contents
        fill_ramp(16'hB000);
        run_op(2'b10, 13'h00C0, -1, 18);
        check_val("rst_mid_done", ndone, 32'd0);
        check_val("rst_mid_we_cycles", nwe, 32'd19);
        check_val("rst_mid_we_after", {31'd0, bus_if.pm_we_o}, 32'd0);
        check_val("rst_mid_busy_after", {31'd0, bus_if.busy_o}, 32'd0);
        for (int i = 0; i < 64; i++) begin
            a = 13'(13'h00C0 + i);
            check_val("rst_mid_data", {16'd0, pm_mem[a]}, (i < 19) ? 32'(16'hB000 + i) : 32'(16'hA000 + i));
        end

        // Overwritten fill index; reset must also have cleared the buffer
        spm_pulse(2'b00, 13'h0005, 16'h1234);
        spm_pulse(2'b00, 13'h0005, 16'h5678);
        run_op(2'b10, 13'h0100, -1, -1);
        check_full_op("overwrite");
        check_val("overwrite_word5", {16'd0, pm_mem[13'h0105]}, 32'h00005678);
        check_val("overwrite_word4", {16'd0, pm_mem[13'h0104]}, 32'h0000FFFF);
        check_val("overwrite_word63", {16'd0, pm_mem[13'h013F]}, 32'h0000FFFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
